// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: op and state encodings shared by the multiply/divide unit
package mult_div_unit_pkg;
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;
endpackage

// File: rtl/mult_div_unit_step.sv
// mult_div_unit_step: one shift-add (multiply) or restoring shift-subtract (divide) iteration
module mult_div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic               mul_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);
  logic [WIDTH:0] sum, top, diff;
  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    top   = acc_i[2*WIDTH-1:WIDTH-1];
    diff  = top - {1'b0, opnd_i};
    // multiply consumes multiplier bits LSB-first; divide shifts quotient bits in at LSB
    acc_o = mul_i   ? {sum, acc_i[WIDTH-1:1]} :
            diff[WIDTH] ? {top[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0} :
                          {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the HI/LO registers
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
  logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
  logic               mul_q, mul_d, neg_q, neg_d, negr_q, negr_d, done_q;
  logic               is_sgn, is_mul, is_md;
  mult_div_unit_step #(.WIDTH(WIDTH)) u_step (
    .mul_i (mul_q),
    .acc_i (acc_q),
    .opnd_i(opnd_q),
    .acc_o (step_acc)
  );
  assign is_sgn = (op == MDU_MULT) || (op == MDU_DIV);
  assign is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
  assign is_md  = op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
  assign a_mag  = (is_sgn && A[WIDTH-1]) ? -A : A;
  assign b_mag  = (is_sgn && B[WIDTH-1]) ? -B : B;
  assign prod   = neg_q ? -acc_q : acc_q;
  assign quo    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem    = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    mul_d   = mul_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (is_md) begin
          state_d = S_CALC;
          cnt_d   = '0;
          mul_d   = is_mul;
          opnd_d  = is_mul ? a_mag : b_mag;
          acc_d   = {{WIDTH{1'b0}}, is_mul ? b_mag : a_mag};
          // a zero divisor keeps the all-ones quotient unsigned; the remainder sign fix restores A
          neg_d   = is_sgn && (A[WIDTH-1] ^ B[WIDTH-1]) && (is_mul || (|B));
          negr_d  = is_sgn && A[WIDTH-1];
        end else begin
          hi_d = (op == MDU_MTHI) ? A : hi_q;
          lo_d = (op == MDU_MTLO) ? A : lo_q;
        end
      end
      S_CALC: begin
        acc_d   = step_acc;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH - 1)) ? S_FIX : S_CALC;
      end
      S_FIX: begin
        state_d = S_IDLE;
        hi_d    = mul_q ? prod[2*WIDTH-1:WIDTH] : rem;
        lo_d    = mul_q ? prod[WIDTH-1:0] : quo;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      mul_q   <= mul_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= (state_q == S_FIX);
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench with directed MULT/DIV/MTHI/MTLO vectors
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [63:0] sb_q[$];
  int          errors = 0, checks = 0, dones = 0;
  mult_div_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .A    (a),
    .B    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done) begin
    logic [63:0] exp_v;
    dones++;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL spurious_done: got done with hi=%h lo=%h, required no done", hi, lo);
    end else begin
      exp_v = sb_q.pop_front();
      if ({hi, lo} !== exp_v || busy !== 1'b0) begin
        errors++;
        $display("FAIL result: got hi=%h lo=%h busy=%b, required hi=%h lo=%h busy=0",
                 hi, lo, busy, exp_v[63:32], exp_v[31:0]);
      end
    end
  end
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask
  task automatic pulse(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] eh, input logic [31:0] el);
    sb_q.push_back({eh, el});
    pulse(o, x, y);
  endtask
  task automatic wait_done(input string name);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got no done within 40 cycles, required done", name);
  endtask
  initial begin
    int bcnt, lat, d0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset", {30'd0, busy, done, hi, lo}, 66'd0);
    @(posedge clk); #1;
    go(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    bcnt = 0; lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
      if (busy) bcnt++;
    end
    check("latency", 64'(lat), 64'd34);
    check("busy_cycles", 64'(bcnt), 64'd33);
    go(MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB); wait_done("mult_neg");
    go(MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000); wait_done("mult_min");
    go(MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD); wait_done("div_neg_a");
    go(MDU_DIVU,  32'd7,        32'd2,        32'd1,        32'd3);        wait_done("divu");
    go(MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD); wait_done("div_neg_b");
    go(MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000); wait_done("div_ovf");
    go(MDU_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF); wait_done("divu_zero");
    go(MDU_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF); wait_done("div_zero");
    go(MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
    repeat (3) @(posedge clk);
    #1 pulse(MDU_MULTU, 32'd9, 32'd9);
    wait_done("ignore_start");
    @(posedge clk); #1;
    go(MDU_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("abort_state", {30'd0, busy, done, hi, lo}, 66'd0);
    d0 = dones;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(dones), 64'(d0));
    @(posedge clk); #1;
    pulse(MDU_MTLO, 32'h1234, 32'd0);
    @(negedge clk);
    check("mtlo", {30'd0, busy, done, hi, lo}, {34'd0, 32'h1234});
    @(posedge clk); #1;
    pulse(MDU_MTHI, 32'h55, 32'd0);
    @(negedge clk);
    check("mthi", {hi, lo}, {32'h55, 32'h1234});
    @(posedge clk); #1;
    go(MDU_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);
    repeat (2) @(posedge clk);
    #1 pulse(MDU_MTHI, 32'hDEAD, 32'd0);
    @(negedge clk);
    check("mthi_busy", {hi, lo}, {32'h55, 32'h1234});
    wait_done("mthi_busy");
    @(posedge clk); #1;
    go(MDU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);
    wait_done("b2b_first");
    go(MDU_MULTU, 32'd9, 32'd9, 32'd0, 32'd81);
    wait_done("b2b_second");
    repeat (3) @(negedge clk);
    check("queue_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
